// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core_ctrl sequencer: instruction-info bit indices,
// widths, and the state/phase encodings used by the controller and its bus-cycle unit.
package core_ctrl_pkg;

    localparam int INSTSIZE = 4;
    localparam int INST_GO6 = 0;
    localparam int INST_DAD = 1;
    localparam int INST_HLT = 2;
    localparam int INST_DIO = 3;
    localparam int TSTBITS  = 3;

    // Instruction-level states; F1-F3/FW and M1-M3/MW are ST_BUS combined with a bus phase.
    typedef enum logic [3:0] {
        ST_RST,
        ST_BUS,
        ST_F4,
        ST_F5,
        ST_F6,
        ST_WB,
        ST_D1,
        ST_D2,
        ST_D3,
        ST_D4,
        ST_D5,
        ST_D6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_T1,
        PH_T2,
        PH_TW,
        PH_T3
    } phase_t;

    typedef enum logic {
        KIND_CODE,
        KIND_DATA
    } kind_t;

endpackage

// File: rtl/core_ctrl_bus_cycle.sv
// One external read cycle: T1 (address latch), T2/TW (read, wait for ready), T3 (capture).
// Shared by opcode fetch (code) and operand/IO reads (data); o_done marks T3.
module core_ctrl_bus_cycle
    import core_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  kind_t              i_kind,
    input  logic               i_io,
    input  logic               i_rdy,
    output logic               o_ale,
    output logic               o_rd,
    output logic               o_io,
    output logic               o_enb_code,
    output logic               o_enb_data,
    output logic               o_pc_inc,
    output logic               o_done,
    output kind_t              o_kind,
    output logic [TSTBITS-1:0] o_tstate
);

    phase_t r_phase;
    phase_t w_phase_nxt;
    kind_t  r_kind;
    logic   r_io;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_kind  <= KIND_CODE;
            r_io    <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            if (i_start) begin
                r_kind <= i_kind;
                r_io   <= i_io;
            end
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (i_start) begin
            w_phase_nxt = PH_T1;
        end else begin
            case (r_phase)
                PH_T1:        w_phase_nxt = PH_T2;
                PH_T2, PH_TW: w_phase_nxt = i_rdy ? PH_T3 : PH_TW;
                PH_T3:        w_phase_nxt = PH_IDLE;
                default:      w_phase_nxt = PH_IDLE;
            endcase
        end
    end

    always_comb begin
        o_ale      = (r_phase == PH_T1);
        o_rd       = (r_phase == PH_T2) || (r_phase == PH_TW) || (r_phase == PH_T3);
        o_io       = r_io && (r_phase != PH_IDLE);
        o_done     = (r_phase == PH_T3);
        o_enb_code = o_done && (r_kind == KIND_CODE);
        o_enb_data = o_done && (r_kind == KIND_DATA);
        o_pc_inc   = o_done;
        o_kind     = r_kind;
        case (r_phase)
            PH_T1:        o_tstate = 3'd1;
            PH_T2, PH_TW: o_tstate = 3'd2;
            PH_T3:        o_tstate = 3'd3;
            default:      o_tstate = 3'd0;
        endcase
    end

endmodule

// File: rtl/core_ctrl.sv
// Machine-cycle / T-state sequencer for the alureg datapath: dispatches on the
// decoded instruction in T4 and drives datapath strobes plus bus read cycles.
//
// state   | meaning
// RST     | held in reset, all outputs low
// BUS     | bus cycle in flight (F1-F3/FW or M1-M3/MW, see bus-cycle phase)
// F4      | register read, instruction dispatch
// F5, F6  | extra T-states of 6-T instructions, write in F6
// WB      | write back after operand/IO read
// D1..D6  | two bus-idle 3-T cycles of DAD
// HALT    | halted until reset
module core_ctrl
    import core_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTSIZE-1:0] chk_inst,
    input  logic                need_mem,
    input  logic                bus_rdy,
    output logic                enb_code,
    output logic                enb_data,
    output logic                enb_rreg,
    output logic                enb_wreg,
    output logic                bus_ale,
    output logic                bus_rd,
    output logic                bus_io,
    output logic                pc_inc,
    output logic                dad_step,
    output logic                halted,
    output logic [TSTBITS-1:0]  tstate
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_dio;

    logic               w_start;
    kind_t              w_kind;
    logic               w_start_io;
    logic               w_bc_done;
    logic               w_bc_io;
    kind_t              w_bc_kind;
    logic [TSTBITS-1:0] w_bc_tstate;

    core_ctrl_bus_cycle u_bus_cycle (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_kind     (w_kind),
        .i_io       (w_start_io),
        .i_rdy      (bus_rdy),
        .o_ale      (bus_ale),
        .o_rd       (bus_rd),
        .o_io       (w_bc_io),
        .o_enb_code (enb_code),
        .o_enb_data (enb_data),
        .o_pc_inc   (pc_inc),
        .o_done     (w_bc_done),
        .o_kind     (w_bc_kind),
        .o_tstate   (w_bc_tstate)
    );

    assign bus_io = w_bc_io;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RST;
            r_dio   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_F4) r_dio <= chk_inst[INST_DIO];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_kind      = KIND_CODE;
        w_start_io  = 1'b0;
        enb_rreg    = 1'b0;
        enb_wreg    = 1'b0;
        dad_step    = 1'b0;
        halted      = 1'b0;
        tstate      = 3'd0;
        case (r_state)
            ST_RST: begin
                w_state_nxt = ST_BUS;
                w_start     = 1'b1;
            end
            ST_BUS: begin
                tstate = w_bc_tstate;
                if (w_bc_done) begin
                    if (w_bc_kind == KIND_CODE) begin
                        w_state_nxt = ST_F4;
                    end else if (r_dio && !w_bc_io) begin
                        // operand byte is the port number; follow it with the IO cycle
                        w_start    = 1'b1;
                        w_kind     = KIND_DATA;
                        w_start_io = 1'b1;
                    end else begin
                        w_state_nxt = ST_WB;
                    end
                end
            end
            ST_F4: begin
                tstate   = 3'd4;
                enb_rreg = 1'b1;
                if (chk_inst[INST_HLT]) begin
                    w_state_nxt = ST_HALT;
                end else if (chk_inst[INST_DAD]) begin
                    w_state_nxt = ST_D1;
                end else if (chk_inst[INST_DIO] || need_mem) begin
                    w_state_nxt = ST_BUS;
                    w_start     = 1'b1;
                    w_kind      = KIND_DATA;
                end else if (chk_inst[INST_GO6]) begin
                    w_state_nxt = ST_F5;
                end else begin
                    enb_wreg    = 1'b1;
                    w_state_nxt = ST_BUS;
                    w_start     = 1'b1;
                end
            end
            ST_F5: begin
                tstate      = 3'd5;
                enb_rreg    = 1'b1;
                w_state_nxt = ST_F6;
            end
            ST_F6: begin
                tstate      = 3'd6;
                enb_rreg    = 1'b1;
                enb_wreg    = 1'b1;
                w_state_nxt = ST_BUS;
                w_start     = 1'b1;
            end
            ST_WB: begin
                tstate      = 3'd4;
                enb_rreg    = 1'b1;
                enb_wreg    = 1'b1;
                w_state_nxt = ST_BUS;
                w_start     = 1'b1;
            end
            ST_D1: begin tstate = 3'd1; w_state_nxt = ST_D2; end
            ST_D2: begin tstate = 3'd2; w_state_nxt = ST_D3; end
            ST_D3: begin tstate = 3'd3; dad_step = 1'b1; w_state_nxt = ST_D4; end
            ST_D4: begin tstate = 3'd1; w_state_nxt = ST_D5; end
            ST_D5: begin tstate = 3'd2; w_state_nxt = ST_D6; end
            ST_D6: begin
                tstate      = 3'd3;
                dad_step    = 1'b1;
                enb_wreg    = 1'b1;
                w_state_nxt = ST_BUS;
                w_start     = 1'b1;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: builds a per-cycle plan of inputs and expected outputs from
// instruction-level rules, a driver replays it, a monitor compares every cycle.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic [INSTSIZE-1:0] chk_inst;
    logic                need_mem;
    logic                bus_rdy;
    logic enb_code, enb_data, enb_rreg, enb_wreg, bus_ale, bus_rd, bus_io;
    logic pc_inc, dad_step, halted;
    logic [TSTBITS-1:0]  tstate;

    always #5 clk = ~clk;

    core_ctrl dut (
        .clk(clk), .rst(rst), .chk_inst(chk_inst), .need_mem(need_mem), .bus_rdy(bus_rdy),
        .enb_code(enb_code), .enb_data(enb_data), .enb_rreg(enb_rreg), .enb_wreg(enb_wreg),
        .bus_ale(bus_ale), .bus_rd(bus_rd), .bus_io(bus_io), .pc_inc(pc_inc),
        .dad_step(dad_step), .halted(halted), .tstate(tstate)
    );

    localparam logic [12:0] B_CODE = 13'h1000;
    localparam logic [12:0] B_DATA = 13'h0800;
    localparam logic [12:0] B_RREG = 13'h0400;
    localparam logic [12:0] B_WREG = 13'h0200;
    localparam logic [12:0] B_ALE  = 13'h0100;
    localparam logic [12:0] B_RD   = 13'h0080;
    localparam logic [12:0] B_IO   = 13'h0040;
    localparam logic [12:0] B_PC   = 13'h0020;
    localparam logic [12:0] B_STEP = 13'h0010;
    localparam logic [12:0] B_HALT = 13'h0008;
    localparam logic [12:0] NO_TST = 13'h1FF8;

    localparam int T_PLAIN = 0, T_GO6 = 1, T_MEM = 2, T_DAD = 3, T_DIO = 4, T_HLT = 5;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [3:0]  chk;
        logic        nm;
        logic [12:0] exp;
        logic [12:0] care;
    } cyc_t;

    cyc_t plan[$];
    cyc_t tmp[$];
    cyc_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    function automatic cyc_t cy(logic [12:0] e);
        cyc_t c;
        c.rst  = 1'b0;
        c.rdy  = 1'($urandom);
        c.chk  = 4'($urandom);
        c.nm   = 1'($urandom);
        c.exp  = e;
        c.care = 13'h1FFF;
        return c;
    endfunction

    // One bus read: address, read with 'waits' not-ready cycles, capture.
    task automatic gen_bus(bit data, bit io, int waits);
        cyc_t c;
        logic [12:0] iob;
        iob = io ? B_IO : 13'd0;
        tmp.push_back(cy(B_ALE | iob | 13'd1));
        c = cy(B_RD | iob | 13'd2);
        c.rdy = (waits == 0);
        tmp.push_back(c);
        for (int w = 0; w < waits; w++) begin
            c = cy(B_RD | iob | 13'd2);
            c.rdy = (w == waits - 1);
            tmp.push_back(c);
        end
        tmp.push_back(cy(B_RD | iob | B_PC | (data ? B_DATA : B_CODE) | 13'd3));
    endtask

    task automatic gen_instr(int k, int w0, int w1, int w2);
        cyc_t c;
        gen_bus(1'b0, 1'b0, w0);
        c = cy(B_RREG | 13'd4);
        case (k)
            T_PLAIN: begin c.chk = 4'b0000; c.nm = 1'b0; c.exp |= B_WREG; end
            T_GO6:   begin c.chk = 4'b0001; c.nm = 1'b0; end
            T_MEM:   begin c.chk = {3'b000, 1'($urandom)}; c.nm = 1'b1; end
            T_DAD:   c.chk = {1'($urandom), 1'b0, 1'b1, 1'($urandom)};
            T_DIO:   c.chk = {1'b1, 2'b00, 1'($urandom)};
            default: c.chk[2] = 1'b1;
        endcase
        tmp.push_back(c);
        case (k)
            T_GO6: begin
                tmp.push_back(cy(B_RREG | 13'd5));
                tmp.push_back(cy(B_RREG | B_WREG | 13'd6));
            end
            T_MEM, T_DIO: begin
                gen_bus(1'b1, 1'b0, w1);
                if (k == T_DIO) gen_bus(1'b1, 1'b1, w2);
                c = cy(B_RREG | B_WREG);
                c.care = NO_TST;
                tmp.push_back(c);
            end
            T_DAD: begin
                for (int i = 0; i < 6; i++) begin
                    c = cy(13'((i % 3) + 1));
                    if (i == 2 || i == 5) c.exp |= B_STEP;
                    if (i == 5) c.exp |= B_WREG;
                    tmp.push_back(c);
                end
            end
            T_HLT: begin
                for (int i = 0; i < 2 + int'($urandom_range(0, 3)); i++) begin
                    c = cy(B_HALT);
                    c.care = NO_TST;
                    tmp.push_back(c);
                end
            end
            default: ;
        endcase
    endtask

    // abort_at: -1 none, -2 random cycle, else cycle index carrying rst=1
    task automatic emit(int k, int w0, int w1, int w2, int abort_at);
        cyc_t c;
        int   a;
        tmp.delete();
        gen_instr(k, w0, w1, w2);
        a = abort_at;
        if (k == T_HLT) a = tmp.size() - 1;
        else if (a == -2) a = $urandom_range(0, tmp.size() - 1);
        if (a >= 0) begin
            while (tmp.size() > a + 1) void'(tmp.pop_back());
            c = tmp[tmp.size() - 1];
            c.rst = 1'b1;
            tmp[tmp.size() - 1] = c;
            if ($urandom_range(0, 1) == 1) begin
                c = cy(13'd0);
                c.rst = 1'b1;
                tmp.push_back(c);
            end
            tmp.push_back(cy(13'd0));
        end
        foreach (tmp[i]) plan.push_back(tmp[i]);
    endtask

    always @(negedge clk) begin
        cyc_t        c;
        logic [12:0] act;
        if (sb.size() > 0) begin
            c   = sb.pop_front();
            act = {enb_code, enb_data, enb_rreg, enb_wreg, bus_ale, bus_rd, bus_io,
                   pc_inc, dad_step, halted, tstate};
            checks++;
            if (((act ^ c.exp) & c.care) !== 13'd0) begin
                failures++;
                $display("FAIL outputs@cyc%0d got=%b want=%b care=%b (code,data,rreg,wreg,ale,rd,io,pc,step,halt,tst)",
                         cyc_no, act, c.exp, c.care);
            end
            cyc_no++;
        end
    end

    initial begin
        cyc_t c;
        int   k;
        rst      = 1'b1;
        bus_rdy  = 1'b0;
        chk_inst = '0;
        need_mem = 1'b0;

        for (int i = 0; i < 2; i++) begin
            c = cy(13'd0);
            c.rst = 1'b1;
            plan.push_back(c);
        end
        plan.push_back(cy(13'd0));

        emit(T_PLAIN, 0, 0, 0, -1);
        emit(T_PLAIN, 2, 0, 0, -1);
        emit(T_MEM,   0, 0, 0, -1);
        emit(T_DAD,   0, 0, 0, -1);
        emit(T_DIO,   0, 0, 0, -1);
        emit(T_HLT,   0, 0, 0, -1);
        emit(T_PLAIN, 0, 0, 0, 1);
        emit(T_GO6,   1, 0, 0, -1);
        emit(T_DIO,   1, 2, 3, -1);

        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 5);
            emit(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) ? -2 : -1);
        end

        foreach (plan[i]) begin
            @(posedge clk);
            #1;
            rst      = plan[i].rst;
            bus_rdy  = plan[i].rdy;
            chk_inst = plan[i].chk;
            need_mem = plan[i].nm;
            sb.push_back(plan[i]);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
